// File: rtl/alu_pkg.sv
// Shared opcode constants, FSM state type and helpers for the ALU request sequencer.
package alu_pkg;

  localparam logic [4:0] OP_AND  = 5'd0;
  localparam logic [4:0] OP_OR   = 5'd1;
  localparam logic [4:0] OP_NOT  = 5'd2;
  localparam logic [4:0] OP_MUL  = 5'd3;
  localparam logic [4:0] OP_DIV  = 5'd4;
  localparam logic [4:0] OP_SHR  = 5'd5;
  localparam logic [4:0] OP_SHL  = 5'd6;
  localparam logic [4:0] OP_LAST = 5'd6;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StDone
  } state_e;

  function automatic logic is_muldiv(input logic [4:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_op_sequencer.sv
// Holds ALU inputs for an opcode-dependent number of cycles and returns a tagged response.
// Optional macro ALU_DIVZERO_TRAP_EN: DIV by zero reports an error instead of all-ones data.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned TAG_W         = 4,
  parameter int unsigned SIMPLE_CYCLES = 1,
  parameter int unsigned MULDIV_CYCLES = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [4:0]        req_op_i,
  input  logic [DATA_W-1:0] req_a_i,
  input  logic [DATA_W-1:0] req_b_i,
  input  logic [TAG_W-1:0]  req_tag_i,
  output logic [DATA_W-1:0] alu_a_o,
  output logic [DATA_W-1:0] alu_b_o,
  output logic [4:0]        alu_ctrl_o,
  input  logic [DATA_W-1:0] alu_y_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_data_o,
  output logic [TAG_W-1:0]  rsp_tag_o,
  output logic              rsp_err_o
);

  localparam int unsigned MaxCycles = (SIMPLE_CYCLES > MULDIV_CYCLES) ? SIMPLE_CYCLES
                                                                      : MULDIV_CYCLES;
  localparam int unsigned CntW = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic [4:0]        alu_ctrl_q, alu_ctrl_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_ctrl_d  = alu_ctrl_q;
    tag_d       = tag_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;

    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          tag_d = req_tag_i;
          if (req_op_i > OP_LAST) begin
            // Illegal opcodes bypass the ALU so it is never driven with them.
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_data_d  = '0;
            state_d     = StDone;
          end else if ((req_op_i == OP_DIV) && (req_b_i == '0)) begin
            rsp_valid_d = 1'b1;
`ifdef ALU_DIVZERO_TRAP_EN
            rsp_err_d   = 1'b1;
            rsp_data_d  = '0;
`else
            rsp_err_d   = 1'b0;
            rsp_data_d  = '1;
`endif
            state_d     = StDone;
          end else begin
            alu_a_d    = req_a_i;
            alu_b_d    = req_b_i;
            alu_ctrl_d = req_op_i;
            cnt_d      = is_muldiv(req_op_i) ? CntW'(MULDIV_CYCLES - 1)
                                             : CntW'(SIMPLE_CYCLES - 1);
            state_d    = StExec;
          end
        end
      end
      StExec: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CntW'(1);
        end else begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = alu_y_i;
          rsp_err_d   = 1'b0;
          state_d     = StDone;
        end
      end
      StDone: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_ctrl_q  <= '0;
      tag_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_ctrl_q  <= alu_ctrl_d;
      tag_q       <= tag_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // No same-cycle bypass: ready only once the FSM is back in idle.
  assign req_ready_o = (state_q == StIdle);
  assign alu_a_o     = alu_a_q;
  assign alu_b_o     = alu_b_q;
  assign alu_ctrl_o  = alu_ctrl_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_tag_o   = tag_q;
  assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer with a behavioural ALU model on alu_y.
module tb_alu_op_sequencer;
  import alu_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned TW = 4;
  localparam int unsigned SC = 1;
  localparam int unsigned MC = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready;
  logic [4:0]    req_op;
  logic [DW-1:0] req_a, req_b;
  logic [TW-1:0] req_tag;
  logic [DW-1:0] alu_a, alu_b, alu_y;
  logic [4:0]    alu_ctrl;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_data;
  logic [TW-1:0] rsp_tag;
  logic          rsp_err;

  typedef struct {
    logic [DW-1:0] data;
    logic [TW-1:0] tag;
    logic          err;
    int            lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass = 0;
  logic guard_bad = 1'b0;

  alu_op_sequencer #(
    .DATA_W       (DW),
    .TAG_W        (TW),
    .SIMPLE_CYCLES(SC),
    .MULDIV_CYCLES(MC)
  ) u_dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .req_valid_i(req_valid),
    .req_ready_o(req_ready),
    .req_op_i   (req_op),
    .req_a_i    (req_a),
    .req_b_i    (req_b),
    .req_tag_i  (req_tag),
    .alu_a_o    (alu_a),
    .alu_b_o    (alu_b),
    .alu_ctrl_o (alu_ctrl),
    .alu_y_i    (alu_y),
    .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready),
    .rsp_data_o (rsp_data),
    .rsp_tag_o  (rsp_tag),
    .rsp_err_o  (rsp_err)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] alu_ref(input logic [4:0] op, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
    case (op)
      5'd0:    return a & b;
      5'd1:    return a | b;
      5'd2:    return ~a;
      5'd3:    return a * b;
      5'd4:    return (b == '0) ? '0 : a / b;
      5'd5:    return a >> 3;
      5'd6:    return a << 2;
      default: return '0;
    endcase
  endfunction

  always_comb alu_y = alu_ref(alu_ctrl, alu_a, alu_b);

  // The ALU must never see an illegal opcode or a zero divisor.
  always @(negedge clk) begin
    if (!rst && ((alu_ctrl > OP_LAST) || (alu_ctrl == OP_DIV && alu_b == '0))) guard_bad = 1'b1;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [TW-1:0] tag);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_tag   = tag;
    tick();
    req_valid = 1'b0;
    req_op    = 5'($urandom);
    req_a     = $urandom;
    req_b     = $urandom;
    req_tag   = 4'($urandom);
  endtask

  task automatic run_op(input logic [4:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [TW-1:0] tag, input logic err_exp,
                        input logic [DW-1:0] data_exp, input int hold);
    exp_t e;
    int   n;
    logic bypass;
    logic [DW-1:0] d0;
    bypass = (op > OP_LAST) || (op == OP_DIV && b == '0);
    e.data = data_exp;
    e.tag  = tag;
    e.err  = err_exp;
    e.lat  = bypass ? 1 : (is_muldiv(op) ? MC + 1 : SC + 1);
    exp_q.push_back(e);
    rsp_ready = (hold == 0);
    check_eq("req_ready_before", 64'(req_ready), 64'd1);
    drive(op, a, b, tag);
    n = 0;
    while (!rsp_valid && n < 40) begin
      if (!bypass) begin
        check_eq("alu_a_hold", 64'(alu_a), 64'(a));
        check_eq("alu_b_hold", 64'(alu_b), 64'(b));
        check_eq("alu_ctrl_hold", 64'(alu_ctrl), 64'(op));
      end
      tick();
      n++;
    end
    e = exp_q.pop_front();
    check_eq("latency", 64'(n + 1), 64'(e.lat));
    check_eq("rsp_data", 64'(rsp_data), 64'(e.data));
    check_eq("rsp_tag", 64'(rsp_tag), 64'(e.tag));
    check_eq("rsp_err", 64'(rsp_err), 64'(e.err));
    d0 = rsp_data;
    for (int i = 0; i < hold; i++) begin
      tick();
      check_eq("hold_valid", 64'(rsp_valid), 64'd1);
      check_eq("hold_data", 64'(rsp_data), 64'(d0));
      check_eq("hold_ready_low", 64'(req_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    tick();
    check_eq("post_valid_low", 64'(rsp_valid), 64'd0);
    check_eq("post_ready_high", 64'(req_ready), 64'd1);
  endtask

  initial begin
    logic          seen;
    logic [4:0]    op;
    logic [DW-1:0] a, b;
    rst = 1'b1;
    req_valid = 1'b0;
    req_op = '0;
    req_a = '0;
    req_b = '0;
    req_tag = '0;
    rsp_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check_eq("rst_req_ready", 64'(req_ready), 64'd1);
    check_eq("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check_eq("rst_rsp_data", 64'(rsp_data), 64'd0);
    check_eq("rst_alu_ctrl", 64'(alu_ctrl), 64'd0);
    check_eq("rst_alu_a", 64'(alu_a), 64'd0);

    // Reset while a response is pending in DONE.
    rsp_ready = 1'b0;
    drive(OP_OR, 32'h1234, 32'h5678, 4'd9);
    tick();
    check_eq("rst_done_pre_valid", 64'(rsp_valid), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("rst_done_valid", 64'(rsp_valid), 64'd0);
    check_eq("rst_done_ready", 64'(req_ready), 64'd1);
    check_eq("rst_done_ctrl", 64'(alu_ctrl), 64'd0);
    check_eq("rst_done_tag", 64'(rsp_tag), 64'd0);

    // Reset mid-EXEC must drop the operation.
    rsp_ready = 1'b1;
    drive(OP_MUL, 32'd5, 32'd5, 4'd5);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (rsp_valid) seen = 1'b1;
      tick();
    end
    check_eq("rst_exec_no_rsp", 64'(seen), 64'd0);

    run_op(OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'd3, 1'b0, 32'hF000_F000, 0);
    run_op(OP_MUL, 32'd7, 32'd6, 4'd1, 1'b0, 32'd42, 0);
    run_op(OP_SHR, 32'h80, 32'h0, 4'd2, 1'b0, 32'h10, 3);
    run_op(OP_SHL, 32'h3, 32'h0, 4'd4, 1'b0, 32'hC, 3);
    run_op(5'd9, 32'h1, 32'h2, 4'd6, 1'b1, 32'h0, 0);
`ifdef ALU_DIVZERO_TRAP_EN
    run_op(OP_DIV, 32'd100, 32'd0, 4'd7, 1'b1, 32'h0, 0);
`else
    run_op(OP_DIV, 32'd100, 32'd0, 4'd7, 1'b0, 32'hFFFF_FFFF, 0);
`endif
    run_op(OP_DIV, 32'd100, 32'd7, 4'd8, 1'b0, 32'd14, 2);
    run_op(OP_NOT, 32'h0F0F_0000, 32'h0, 4'd10, 1'b0, 32'hF0F0_FFFF, 0);

    for (int i = 0; i < 8; i++) begin
      op = 5'($urandom_range(0, 6));
      a  = $urandom;
      b  = $urandom | 32'h1;
      run_op(op, a, b, 4'(i), 1'b0, alu_ref(op, a, b), i % 2);
    end
    op = 5'($urandom_range(7, 31));
    run_op(op, $urandom, $urandom, 4'd15, 1'b1, 32'h0, 1);

    check_eq("alu_guard", 64'(guard_bad), 64'd0);
    check_eq("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
